serial_rx_fifo: RTL and testbench
=================================

# serial_rx_fifo

Keyboard-side receive front end for the console serial interface. It synchronises and oversamples the raw `rx` pin, deframes 8N1 characters and queues them in a small FIFO. It presents the oldest character, together with a "character available" flag, to the console I/O controller, which handles KSF/KRB/KCC. It is a drop-in superset of the existing receiver port list, adding overrun and framing status, so the controller no longer loses characters typed while the CPU is busy.

## Interface
Parameters:
- `CLK_FREQ`, 100000000: system clock frequency in Hz.
- `BAUD`, 115200: line rate. Divider `DIV = CLK_FREQ/(BAUD*16)`, integer-truncated (54 at defaults).
- `DEPTH`, 4: FIFO entries, a power of two ≥ 2.

Ports:
- `clk`  in  1: system clock; all logic is on the rising edge.
- `reset`  in  1: synchronous, active-low reset.
- `clear`  in  1: synchronous, active-high flush (CAF/console clear).
- `rx`  in  1: asynchronous serial input; idles high.
- `clear_flag`  in  1: pop request; may be held high for several cycles.
- `flag`  out  1: FIFO not empty.
- `char0`  out  [0:7]: head-of-FIFO character; `char0[7]` = LSB = first data bit received.
- `count`  out  [$clog2(DEPTH):0]: number of FIFO entries.
- `overrun`  out  1: sticky; a character was dropped because the FIFO was full.
- `framing_err`  out  1: sticky; a stop bit was sampled low.

## Operation
- `rx` passes through a 2-FF synchronizer that resets to 1. All decoding uses the synchronized value `rxs`.
- The tick counter counts 0..DIV-1 and emits one `tick` per wrap. It reloads to 0 whenever the FSM enters START.
- Each bit period is 16 ticks. The bit value is the majority of `rxs` sampled at ticks 7, 8 and 9. The decision is made at tick 9.
- FSM states:
  - IDLE: when `rxs`=0, go to START and clear the sample counter.
  - START: at the bit decision, a result of 1 is a false start and returns to IDLE. A result of 0 goes to DATA with the bit index at 0.
  - DATA: at each decision, shift the bit into the LSB-first shift register. After the 8th bit, go to STOP.
  - STOP: at the decision, a 1 pushes the byte and returns to IDLE. A 0 sets `framing_err`, discards the byte and goes to BREAK.
  - BREAK: wait for `rxs`=1, then return to IDLE. A held-low line does not retrigger START.
- Pop is edge-triggered: one entry is removed on the first cycle `clear_flag` is seen high after being low (registered edge detect). Holding `clear_flag` high pops exactly once.
- A pop on an empty FIFO is ignored.
- A push with the FIFO full and no pop in the same cycle drops the new byte and sets `overrun`. A push and a pop in the same cycle both occur: `count` is unchanged and the head advances. This also applies when the FIFO is full.
- `clear` (or `reset`=0) has the following effects:
  - empties the FIFO and sets pointers to 0;
  - clears `overrun` and `framing_err`;
  - returns the FSM to IDLE;
  - clears the pop edge detector to "previously high", so a `clear_flag` held across `clear` does not pop.
- `clear` does not reset the synchronizer.
- `reset` has priority over `clear`, and `clear` has priority over push and pop in the same cycle.

## Timing
- Reset values:
  - `flag`=0, `count`=0, `char0`=8'h00, `overrun`=0, `framing_err`=0;
  - FSM in IDLE;
  - synchronizer = 2'b11.
- `char0` is registered from the head entry and reads 0 when the FIFO is empty. It updates 1 cycle after a push into an empty FIFO, or after a pop.
- `flag` and `count` are registered and update on the cycle after the push or pop.
- Latency: the push occurs at the stop-bit decision, (9×16+9)·DIV clk + 2 sync cycles after the start edge reaches `rx`. `flag` rises 1 clk later.
- Tolerance: at least ±3% baud mismatch is decoded correctly.
- Reset or `clear` mid-character aborts the character with no push and no error set. Reception restarts only on the next falling edge seen in IDLE.
- A new start bit is accepted on the first cycle of IDLE after STOP. Back-to-back characters with one stop bit are received without loss.

## Test plan
- Send 0x41 at BAUD, `clear_flag` low:
  - `flag` rises within (153·DIV+3) clk of the start edge, `char0`=8'h41, `count`=1.
  - Raise `clear_flag` for 5 cycles: exactly one pop, `flag`=0, `count`=0.
- Send 0x55, 0xAA, 0x0F, 0xF0, 0x33 back-to-back with no pops:
  - `count`=4, `overrun`=1.
  - Successive single pops yield 55, AA, 0F, F0 and then `flag`=0.
- Send a low pulse of 6·16·DIV/16 clk (under half a bit) on idle `rx`: no push, FSM back in IDLE, no error.
- Send 0x7E with the stop bit forced low and the line held low for 3 bit times, then released:
  - `framing_err`=1, `count`=0.
  - The next valid 0x31 is received correctly.
- With the FIFO full, arrange a push and a `clear_flag` rising edge in the same cycle: `count` stays 4, the head advances, `overrun`=0.
- Assert `clear` mid-DATA, and assert `reset`=0 with 2 entries queued: all outputs return to their reset values. A subsequent 0x0D is received with `char0`=8'h0D.

Source files
------------

// File: rtl/serial_rx_fifo.sv
// serial_rx_fifo: 16x-oversampled 8N1 receiver queueing characters in a small FIFO
module serial_rx_fifo #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD = 115200,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic rx,
  input  logic clear_flag,
  output logic flag,
  output logic [0:7] char0,
  output logic [$clog2(DEPTH):0] count,
  output logic overrun,
  output logic framing_err
);
  localparam int DIV = CLK_FREQ / (BAUD * 16);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [AW:0] FULL_N = (AW+1)'(DEPTH);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t state, state_n;
  logic [1:0] sync;
  logic rxs, rxs_q;
  logic [TW-1:0] tcnt;
  logic [3:0] scnt, scnt_n;
  logic [1:0] samp;
  logic [2:0] bidx;
  logic [7:0] shreg;
  logic tick, decide, bitv, push;
  logic clr_q, pop_req, do_pop, do_push, full;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] rd, wr, rd_n;
  logic [AW:0] count_n;
  logic [7:0] head_n;
  assign rxs = sync[1];
  assign tick = tcnt == TW'(DIV - 1);
  assign scnt_n = scnt + 4'd1;
  assign decide = tick && scnt_n == 4'd9;
  assign bitv = (samp[0] & samp[1]) | (samp[0] & rxs) | (samp[1] & rxs);
  // Start only on a falling edge, so a line left low by an abort never retriggers
  always_comb begin
    state_n = state;
    push = 1'b0;
    case (state)
      IDLE:  state_n = (rxs_q && !rxs) ? START : IDLE;
      START: state_n = decide ? (bitv ? IDLE : DATA) : START;
      DATA:  state_n = (decide && bidx == 3'd7) ? STOP : DATA;
      STOP: begin
        state_n = decide ? (bitv ? IDLE : BRK) : STOP;
        push = decide & bitv;
      end
      BRK:   state_n = rxs ? IDLE : BRK;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    sync <= reset ? {sync[0], rx} : 2'b11;
    rxs_q <= reset ? rxs : 1'b1;
    if (!reset || clear) begin
      state <= IDLE;
      tcnt <= '0;
      scnt <= '0;
      samp <= '0;
      bidx <= '0;
      shreg <= '0;
      framing_err <= 1'b0;
    end else begin
      state <= state_n;
      tcnt <= (state == IDLE || tick) ? '0 : tcnt + 1'b1;
      scnt <= (state == IDLE) ? '0 : (tick ? scnt_n : scnt);
      if (tick && scnt_n == 4'd7) samp[0] <= rxs;
      if (tick && scnt_n == 4'd8) samp[1] <= rxs;
      bidx <= (state == START) ? 3'd0 : ((decide && state == DATA) ? bidx + 3'd1 : bidx);
      if (decide && state == DATA) shreg <= {bitv, shreg[7:1]};
      if (decide && state == STOP && !bitv) framing_err <= 1'b1;
    end
  end
  assign pop_req = clear_flag & ~clr_q;
  assign full = count == FULL_N;
  assign do_pop = pop_req && count != '0;
  assign do_push = push && (!full || do_pop);
  assign rd_n = do_pop ? rd + 1'b1 : rd;
  assign count_n = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
  // Bypass the incoming byte when it becomes the head in the same cycle
  assign head_n = (count_n == '0) ? 8'h00 : ((do_push && wr == rd_n) ? shreg : mem[rd_n]);
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
      flag <= 1'b0;
      char0 <= 8'h00;
      overrun <= 1'b0;
      clr_q <= 1'b1;
    end else begin
      clr_q <= clear_flag;
      rd <= rd_n;
      wr <= do_push ? wr + 1'b1 : wr;
      count <= count_n;
      flag <= count_n != '0;
      char0 <= head_n;
      overrun <= overrun | (push & full & ~do_pop);
    end
  end
  always_ff @(posedge clk)
    if (reset && !clear && do_push) mem[wr] <= shreg;
endmodule

// File: tb/tb_serial_rx_fifo.sv
// tb_serial_rx_fifo: directed vectors plus hand-written multi-cycle sequences for serial_rx_fifo
module tb_serial_rx_fifo;
  localparam int DIV = 4;
  localparam int BITLEN = 16 * DIV;
  logic clk = 1'b0, reset = 1'b0, clear = 1'b0, rx = 1'b1, clear_flag = 1'b0;
  logic flag, overrun, framing_err;
  logic [0:7] char0;
  logic [2:0] count;
  int n_tests = 0, n_fail = 0, lat = 0;
  typedef struct {
    logic [7:0] tx;
    logic stop;
    int len;
    logic [7:0] exp_char;
    logic [2:0] exp_count;
    logic exp_fe;
  } vec_t;
  vec_t vecs[9];
  logic [7:0] burst[5];
  logic [7:0] fill[5];
  serial_rx_fifo #(.CLK_FREQ(1600000), .BAUD(25000), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .clear(clear), .rx(rx), .clear_flag(clear_flag),
    .flag(flag), .char0(char0), .count(count), .overrun(overrun), .framing_err(framing_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stop, input int len);
    rx = 1'b0;
    wait_clk(len);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clk(len);
    end
    rx = stop;
    wait_clk(len);
  endtask
  task automatic pop(input int hold);
    clear_flag = 1'b1;
    wait_clk(hold);
    clear_flag = 1'b0;
    wait_clk(2);
  endtask
  task automatic do_clear;
    clear = 1'b1;
    wait_clk(1);
    clear = 1'b0;
    wait_clk(1);
  endtask
  initial begin
    vecs[0] = '{8'h41, 1'b1, BITLEN, 8'h41, 3'd1, 1'b0};
    vecs[1] = '{8'h00, 1'b1, BITLEN, 8'h00, 3'd1, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, BITLEN, 8'hFF, 3'd1, 1'b0};
    vecs[3] = '{8'h80, 1'b1, BITLEN, 8'h80, 3'd1, 1'b0};
    vecs[4] = '{8'h01, 1'b1, BITLEN, 8'h01, 3'd1, 1'b0};
    vecs[5] = '{8'hA5, 1'b1, BITLEN - 2, 8'hA5, 3'd1, 1'b0};
    vecs[6] = '{8'h5A, 1'b1, BITLEN + 2, 8'h5A, 3'd1, 1'b0};
    vecs[7] = '{8'hC3, 1'b1, BITLEN + 2, 8'hC3, 3'd1, 1'b0};
    vecs[8] = '{8'h3C, 1'b0, BITLEN, 8'h00, 3'd0, 1'b1};
    burst = '{8'h55, 8'hAA, 8'h0F, 8'hF0, 8'h33};
    fill = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    wait_clk(4);
    chk("rst_flag", flag, 0);
    chk("rst_count", count, 0);
    chk("rst_char0", char0, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_framing", framing_err, 0);
    reset = 1'b1;
    wait_clk(4);
    fork
      send_byte(8'h41, 1'b1, BITLEN);
      begin
        while (!flag && lat < 153 * DIV + 10) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    chk("latency_window", (lat >= 150 * DIV && lat <= 153 * DIV + 3), 1);
    chk("rx41_char0", char0, 8'h41);
    chk("rx41_count", count, 1);
    clear_flag = 1'b1;
    wait_clk(5);
    chk("held_pop_count", count, 0);
    chk("held_pop_flag", flag, 0);
    chk("held_pop_char0", char0, 0);
    clear_flag = 1'b0;
    wait_clk(2);
    do_clear;
    for (int i = 0; i < 5; i++) send_byte(burst[i], 1'b1, BITLEN);
    wait_clk(BITLEN);
    chk("burst_count", count, 4);
    chk("burst_overrun", overrun, 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("burst_head%0d", i), char0, burst[i]);
      pop(3);
    end
    chk("burst_empty_flag", flag, 0);
    chk("burst_empty_char0", char0, 0);
    do_clear;
    rx = 1'b0;
    wait_clk(6 * DIV);
    rx = 1'b1;
    wait_clk(2 * BITLEN);
    chk("glitch_count", count, 0);
    chk("glitch_framing", framing_err, 0);
    for (int i = 0; i < 9; i++) begin
      do_clear;
      send_byte(vecs[i].tx, vecs[i].stop, vecs[i].len);
      rx = 1'b1;
      wait_clk(2 * BITLEN);
      chk($sformatf("vec%0d_char0", i), char0, vecs[i].exp_char);
      chk($sformatf("vec%0d_count", i), count, vecs[i].exp_count);
      chk($sformatf("vec%0d_flag", i), flag, vecs[i].exp_count != 0);
      chk($sformatf("vec%0d_framing", i), framing_err, vecs[i].exp_fe);
    end
    do_clear;
    send_byte(8'h7E, 1'b0, BITLEN);
    wait_clk(3 * BITLEN);
    rx = 1'b1;
    wait_clk(BITLEN);
    chk("break_framing", framing_err, 1);
    chk("break_count", count, 0);
    send_byte(8'h31, 1'b1, BITLEN);
    wait_clk(BITLEN);
    chk("after_break_char0", char0, 8'h31);
    chk("after_break_count", count, 1);
    chk("framing_sticky", framing_err, 1);
    do_clear;
    for (int i = 0; i < 4; i++) send_byte(fill[i], 1'b1, BITLEN);
    wait_clk(4);
    chk("full_count", count, 4);
    chk("full_overrun", overrun, 0);
    fork
      send_byte(fill[4], 1'b1, BITLEN);
      begin
        wait_clk(153 * DIV + 2);
        clear_flag = 1'b1;
      end
    join
    clear_flag = 1'b0;
    wait_clk(2);
    chk("pushpop_count", count, 4);
    chk("pushpop_overrun", overrun, 0);
    for (int i = 1; i < 5; i++) begin
      chk($sformatf("pushpop_head%0d", i), char0, fill[i]);
      pop(2);
    end
    chk("pushpop_drained", count, 0);
    do_clear;
    send_byte(8'h5A, 1'b1, BITLEN);
    send_byte(8'h3C, 1'b0, BITLEN);
    rx = 1'b1;
    wait_clk(BITLEN);
    chk("pre_clear_count", count, 1);
    chk("pre_clear_framing", framing_err, 1);
    fork
      send_byte(8'h00, 1'b1, BITLEN);
      begin
        wait_clk(4 * BITLEN);
        clear = 1'b1;
        wait_clk(1);
        clear = 1'b0;
      end
    join
    wait_clk(2 * BITLEN);
    chk("clr_mid_count", count, 0);
    chk("clr_mid_flag", flag, 0);
    chk("clr_mid_char0", char0, 0);
    chk("clr_mid_framing", framing_err, 0);
    chk("clr_mid_overrun", overrun, 0);
    send_byte(8'h12, 1'b1, BITLEN);
    send_byte(8'h34, 1'b1, BITLEN);
    wait_clk(4);
    chk("two_queued", count, 2);
    clear_flag = 1'b1;
    reset = 1'b0;
    wait_clk(2);
    chk("rst2_flag", flag, 0);
    chk("rst2_count", count, 0);
    chk("rst2_char0", char0, 0);
    chk("rst2_overrun", overrun, 0);
    chk("rst2_framing", framing_err, 0);
    reset = 1'b1;
    wait_clk(4);
    send_byte(8'h0D, 1'b1, BITLEN);
    wait_clk(BITLEN);
    chk("post_rst_char0", char0, 8'h0D);
    chk("held_flag_no_pop", count, 1);
    clear_flag = 1'b0;
    wait_clk(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
